lfsr_gen: RTL and testbench

Parametrised pseudo-random sequence generator. It generalises the fixed 16-bit LFSR to any width and tap polynomial, and supports both Galois and Fibonacci forms. It adds seed load with zero-seed protection, a step enable, and an on-chip period-measurement engine that reports the cycle length of the current sequence. It feeds test-pattern, noise and dither consumers in the design.

---
 rtl/lfsr_gen.sv | 96 +++++++++
 tb/tb_lfsr_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Parametrised Galois/Fibonacci LFSR with seed load, zero-seed substitution and period measurement.
// Load and mode change take effect one edge later; en_in low simply holds all state.
module lfsr_gen #(
  parameter int                WIDTH      = 16,
  parameter logic [WIDTH-1:0]  TAPS       = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0]  RESET_SEED = WIDTH'(1)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en_in,
  input  logic              load_in,
  input  logic [WIDTH-1:0]  seed_in,
  input  logic              mode_in,
  output logic [WIDTH-1:0]  q_out,
  output logic              bit_out,
  output logic              seed_err_out,
  output logic              period_valid_out,
  output logic [WIDTH-1:0]  period_out,
  output logic              locked_out
);

  localparam logic [0:0]       MEASURE = 1'b0;
  localparam logic [0:0]       LOCKED  = 1'b1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] ref_r;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] period_r;
  logic             mode_r;
  logic [0:0]       state_r;
  logic             seed_err_r;
  logic             period_vld_r;

  logic [WIDTH-1:0] next_galois;
  logic [WIDTH-1:0] next_fib;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] load_val;
  logic             seed_zero;

  always_comb begin
    next_galois = (q_r >> 1) ^ (q_r[0] ? TAPS : '0);
    next_fib    = {q_r[WIDTH-2:0], ^(q_r & TAPS)};
    step_next   = mode_r ? next_fib : next_galois;
    seed_zero   = (seed_in == '0);
    load_val    = seed_zero ? WIDTH'(1) : seed_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      q_r          <= RESET_SEED;
      ref_r        <= RESET_SEED;
      count_r      <= '0;
      period_r     <= '0;
      mode_r       <= 1'b0;
      state_r      <= MEASURE;
      seed_err_r   <= 1'b0;
      period_vld_r <= 1'b0;
    end else begin
      seed_err_r   <= 1'b0;
      period_vld_r <= 1'b0;
      if (load_in) begin
        q_r        <= load_val;
        ref_r      <= load_val;
        count_r    <= '0;
        state_r    <= MEASURE;
        seed_err_r <= seed_zero;
      end else if (mode_in != mode_r) begin
        // The state is kept and becomes the new reference for the other form.
        mode_r  <= mode_in;
        ref_r   <= q_r;
        count_r <= '0;
        state_r <= MEASURE;
      end else if (en_in) begin
        q_r <= step_next;
        // A saturated count means the reference was never revisited; report nothing.
        if (step_next == ref_r && count_r != CNT_MAX) begin
          period_r     <= count_r + WIDTH'(1);
          period_vld_r <= 1'b1;
          state_r      <= LOCKED;
          count_r      <= '0;
        end else if (count_r != CNT_MAX) begin
          count_r <= count_r + WIDTH'(1);
        end
      end
    end
  end

  assign q_out            = q_r;
  assign bit_out          = mode_r ? q_r[WIDTH-1] : q_r[0];
  assign seed_err_out     = seed_err_r;
  assign period_valid_out = period_vld_r;
  assign period_out       = period_r;
  assign locked_out       = (state_r == LOCKED);

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: default 16-bit instance plus two 4-bit instances (maximal and short taps).
module tb_lfsr_gen;

  logic clk = 1'b0;
  logic rst;

  logic        en_a, load_a, mode_a;
  logic [15:0] seed_a, q_a, period_a;
  logic        bit_a, err_a, pv_a, lock_a;

  logic        en_b, load_b, mode_b;
  logic [3:0]  seed_b, q_b, period_b;
  logic        bit_b, err_b, pv_b, lock_b;

  logic        en_c, load_c, mode_c;
  logic [3:0]  seed_c, q_c, period_c;
  logic        bit_c, err_c, pv_c, lock_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lfsr_gen u_def (
    .clk_in(clk), .rst_in(rst), .en_in(en_a), .load_in(load_a), .seed_in(seed_a),
    .mode_in(mode_a), .q_out(q_a), .bit_out(bit_a), .seed_err_out(err_a),
    .period_valid_out(pv_a), .period_out(period_a), .locked_out(lock_a)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .RESET_SEED(4'h1)) u_w4c (
    .clk_in(clk), .rst_in(rst), .en_in(en_b), .load_in(load_b), .seed_in(seed_b),
    .mode_in(mode_b), .q_out(q_b), .bit_out(bit_b), .seed_err_out(err_b),
    .period_valid_out(pv_b), .period_out(period_b), .locked_out(lock_b)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'hF), .RESET_SEED(4'h1)) u_w4f (
    .clk_in(clk), .rst_in(rst), .en_in(en_c), .load_in(load_c), .seed_in(seed_c),
    .mode_in(mode_c), .q_out(q_c), .bit_out(bit_c), .seed_err_out(err_c),
    .period_valid_out(pv_c), .period_out(period_c), .locked_out(lock_c)
  );

  typedef struct {
    logic        en;
    logic        load;
    logic [15:0] seed;
    logic        mode;
    logic [15:0] q;
    logic        bo;
    logic        err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps u_w4c until a period pulse; en_b optionally toggles to insert hold cycles.
  task automatic run_pulse(input bit tog, output int steps);
    steps = 0;
    for (int i = 0; i < 200; i++) begin
      en_b = tog ? (i % 2 == 0) : 1'b1;
      tick();
      if (en_b) steps++;
      if (pv_b) break;
    end
    en_b = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [16];
    logic [3:0]  exp_f  [5];
    logic        exp_pv [5];
    int          steps;

    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'hB400, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h5A00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h2D00, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h1680, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0B40, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h05A0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h02D0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0168, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h00B4, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h005A, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h002D, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'hB416, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0001, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 16'h1234, 1'b0, 16'h1234, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h091A, 1'b0, 1'b0};

    exp_f[0] = 4'hF; exp_f[1] = 4'h8; exp_f[2] = 4'h4; exp_f[3] = 4'h2; exp_f[4] = 4'h1;
    exp_pv[0] = 1'b0; exp_pv[1] = 1'b0; exp_pv[2] = 1'b0; exp_pv[3] = 1'b0; exp_pv[4] = 1'b1;

    rst = 1'b0;
    en_a = 1'b0; load_a = 1'b0; mode_a = 1'b0; seed_a = '0;
    en_b = 1'b0; load_b = 1'b0; mode_b = 1'b0; seed_b = '0;
    en_c = 1'b0; load_c = 1'b0; mode_c = 1'b0; seed_c = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_q",      32'(q_a),      32'h1);
    chk("rst_bit",    32'(bit_a),    32'h1);
    chk("rst_err",    32'(err_a),    32'h0);
    chk("rst_pv",     32'(pv_a),     32'h0);
    chk("rst_period", 32'(period_a), 32'h0);
    chk("rst_lock",   32'(lock_a),   32'h0);
    #5 rst = 1'b0;

    // Galois sequence from reset, then zero-seed and load-over-step rows
    foreach (tbl[i]) begin
      en_a = tbl[i].en; load_a = tbl[i].load; seed_a = tbl[i].seed; mode_a = tbl[i].mode;
      tick();
      chk($sformatf("vec%0d_q", i),   32'(q_a),   32'(tbl[i].q));
      chk($sformatf("vec%0d_bit", i), 32'(bit_a), 32'(tbl[i].bo));
      chk($sformatf("vec%0d_err", i), 32'(err_a), 32'(tbl[i].err));
    end

    // Fibonacci from seed 1: the cycle after the load registers the mode without stepping
    en_a = 1'b0; load_a = 1'b1; seed_a = 16'h0001; mode_a = 1'b1;
    tick();
    load_a = 1'b0;
    tick();
    chk("fib_hold_q",   32'(q_a),   32'h0001);
    chk("fib_hold_bit", 32'(bit_a), 32'h0);
    en_a = 1'b1;
    for (int s = 1; s <= 15; s++) begin
      tick();
      if (s == 1)  chk("fib_s1",  32'(q_a), 32'h0002);
      if (s == 10) chk("fib_s10", 32'(q_a), 32'h0400);
      if (s == 11) chk("fib_s11", 32'(q_a), 32'h0801);
      if (s == 13) chk("fib_s13", 32'(q_a), 32'h2005);
      if (s == 15) begin
        chk("fib_s15",     32'(q_a),   32'h8016);
        chk("fib_s15_bit", 32'(bit_a), 32'h1);
      end
    end
    en_a = 1'b0;

    // 4-bit maximal taps: period 15, repeated, with and without hold cycles
    load_b = 1'b1; seed_b = 4'h1;
    tick();
    load_b = 1'b0;
    chk("w4c_load_q",    32'(q_b),    32'h1);
    chk("w4c_load_lock", 32'(lock_b), 32'h0);
    run_pulse(1'b0, steps);
    chk("w4c_p1_steps",  32'(steps),    32'd15);
    chk("w4c_p1_period", 32'(period_b), 32'd15);
    chk("w4c_p1_lock",   32'(lock_b),   32'h1);
    tick();
    chk("w4c_pv_width",  32'(pv_b),     32'h0);
    run_pulse(1'b1, steps);
    chk("w4c_p2_steps",  32'(steps),    32'd15);
    chk("w4c_p2_period", 32'(period_b), 32'd15);
    chk("w4c_p2_lock",   32'(lock_b),   32'h1);

    // Mode change mid-run: hold one cycle, unlock, then a full period in Fibonacci form
    en_b = 1'b1;
    tick(); tick(); tick();
    chk("w4c_pre_mode_q", 32'(q_b), 32'h3);
    mode_b = 1'b1;
    tick();
    chk("w4c_mode_hold_q", 32'(q_b),    32'h3);
    chk("w4c_mode_lock",   32'(lock_b), 32'h0);
    run_pulse(1'b0, steps);
    chk("w4c_fib_steps",  32'(steps),    32'd15);
    chk("w4c_fib_period", 32'(period_b), 32'd15);
    chk("w4c_fib_q",      32'(q_b),      32'h3);

    // Async reset between edges
    en_b = 1'b1;
    tick();
    chk("w4c_fib_step_q", 32'(q_b), 32'h6);
    #2 rst = 1'b1;
    #1;
    chk("arst_q",      32'(q_b),      32'h1);
    chk("arst_lock",   32'(lock_b),   32'h0);
    chk("arst_period", 32'(period_b), 32'h0);
    chk("arst_bit",    32'(bit_b),    32'h1);
    chk("arst_q_def",  32'(q_a),      32'h0001);
    #1 rst = 1'b0;
    mode_b = 1'b0;
    tick();
    chk("arst_resume_q", 32'(q_b), 32'hC);
    en_b = 1'b0;

    // 4-bit taps F: short cycle 1,F,8,4,2,1
    en_c = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("w4f_q%0d", k),  32'(q_c),  32'(exp_f[k]));
      chk($sformatf("w4f_pv%0d", k), 32'(pv_c), 32'(exp_pv[k]));
    end
    en_c = 1'b0;
    chk("w4f_period", 32'(period_c), 32'd5);
    chk("w4f_lock",   32'(lock_c),   32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
